// File: rtl/centroid_div_scheduler_pkg.sv
// Shared definitions for the centroid averaging scheduler.
//   - job/color counts and coordinate widths
//   - FSM state encoding (also exported on the debug port)
//   - clamp helper used when storing divider quotients
package centroid_div_scheduler_pkg;

    localparam int NUM_JOBS   = 8;
    localparam int NUM_COLORS = 4;
    localparam int JOB_W      = 3;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_GUARD  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_STORE  = 3'd5,
        ST_FINISH = 3'd6
    } state_e;

    // Saturate an unsigned quotient to a coordinate limit.
    function automatic logic [DATA_W-1:0] clamp_u32(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/centroid_div_scheduler.sv
// Centroid averaging scheduler.
// On a start pulse in IDLE the per-color x/y sums and pixel counts are
// captured, then eight divide jobs (color = job>>1, axis = job[0]) are
// issued one at a time to an external shared divider. Each quotient is
// clamped to XMAX / YMAX and written to its average slot.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a pass (ignored while busy)
//   sum_x, sum_y, num     four packed 32-bit values, color k at [32k+31:32k]
//   div_start/dividend/divisor, div_ready/quotient   shared divider link
//   avg_x, avg_y          packed 10-bit / 9-bit averages
//   valid_mask            color k produced a fresh average this pass
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   timeout_err           sticky divider timeout flag, cleared on next start
//   state_dbg             current FSM state
// Divider handshake: div_start is a one-cycle request while div_ready is
// high; the divider drops div_ready within one cycle and raises it again
// with div_quotient valid. Operands are held until the quotient is taken.
module centroid_div_scheduler
    import centroid_div_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int XMAX    = 639,
    parameter int YMAX    = 479
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] sum_x,
    input  logic [127:0] sum_y,
    input  logic [127:0] num,
    output logic         div_start,
    output logic [31:0]  div_dividend,
    output logic [31:0]  div_divisor,
    input  logic         div_ready,
    input  logic [31:0]  div_quotient,
    output logic [39:0]  avg_x,
    output logic [35:0]  avg_y,
    output logic [3:0]   valid_mask,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output state_e       state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [JOB_W-1:0]    job_q, job_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [DATA_W-1:0]   cap_sx_q [NUM_COLORS];
    logic [DATA_W-1:0]   cap_sx_d [NUM_COLORS];
    logic [DATA_W-1:0]   cap_sy_q [NUM_COLORS];
    logic [DATA_W-1:0]   cap_sy_d [NUM_COLORS];
    logic [DATA_W-1:0]   cap_n_q  [NUM_COLORS];
    logic [DATA_W-1:0]   cap_n_d  [NUM_COLORS];
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic                div_start_q, div_start_d;
    logic [DATA_W-1:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [39:0]         avg_x_q, avg_x_d;
    logic [35:0]         avg_y_q, avg_y_d;
    logic [3:0]          valid_mask_q, valid_mask_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_err_q, timeout_err_d;

    logic [1:0]          color;
    logic                axis_y;
    logic                advance;
    logic [DATA_W-1:0]   clamped;

    assign color  = job_q[2:1];
    assign axis_y = job_q[0];

    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        wdog_d        = wdog_q;
        cap_sx_d      = cap_sx_q;
        cap_sy_d      = cap_sy_q;
        cap_n_d       = cap_n_q;
        quot_d        = quot_q;
        div_start_d   = 1'b0;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        avg_x_d       = avg_x_q;
        avg_y_d       = avg_y_q;
        valid_mask_d  = valid_mask_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        advance       = 1'b0;
        clamped       = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int k = 0; k < NUM_COLORS; k++) begin
                        cap_sx_d[k] = sum_x[32*k +: 32];
                        cap_sy_d[k] = sum_y[32*k +: 32];
                        cap_n_d[k]  = num[32*k +: 32];
                    end
                    timeout_err_d = 1'b0;
                    busy_d        = 1'b1;
                    job_d         = '0;
                    state_d       = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // A zero pixel count would divide by zero: skip the job and
                // leave the previous average untouched.
                if (cap_n_q[color] == '0) begin
                    valid_mask_d[color] = 1'b0;
                    advance             = 1'b1;
                end else begin
                    dividend_d  = axis_y ? cap_sy_q[color] : cap_sx_q[color];
                    divisor_d   = cap_n_q[color];
                    div_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // div_ready may still show the previous idle level here.
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready) begin
                    quot_d  = div_quotient;
                    state_d = ST_STORE;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_err_d       = 1'b1;
                    valid_mask_d[color] = 1'b0;
                    advance             = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_STORE: begin
                if (axis_y) begin
                    clamped = clamp_u32(quot_q, DATA_W'(YMAX));
                    avg_y_d[int'(color)*Y_W +: Y_W] = clamped[Y_W-1:0];
                end else begin
                    clamped = clamp_u32(quot_q, DATA_W'(XMAX));
                    avg_x_d[int'(color)*X_W +: X_W] = clamped[X_W-1:0];
                    valid_mask_d[color] = 1'b1;
                end
                advance = 1'b1;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (job_q == JOB_W'(NUM_JOBS - 1)) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_FINISH;
            end else begin
                job_d   = job_q + JOB_W'(1);
                state_d = ST_CHECK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            job_q         <= '0;
            wdog_q        <= '0;
            cap_sx_q      <= '{default: '0};
            cap_sy_q      <= '{default: '0};
            cap_n_q       <= '{default: '0};
            quot_q        <= '0;
            div_start_q   <= 1'b0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            avg_x_q       <= '0;
            avg_y_q       <= '0;
            valid_mask_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            wdog_q        <= wdog_d;
            cap_sx_q      <= cap_sx_d;
            cap_sy_q      <= cap_sy_d;
            cap_n_q       <= cap_n_d;
            quot_q        <= quot_d;
            div_start_q   <= div_start_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            avg_x_q       <= avg_x_d;
            avg_y_q       <= avg_y_d;
            valid_mask_q  <= valid_mask_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign div_start    = div_start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign avg_x        = avg_x_q;
    assign avg_y        = avg_y_q;
    assign valid_mask   = valid_mask_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = timeout_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Bench for centroid_div_scheduler: directed scenarios plus randomized
// passes against a behavioural averaging model and a latency-programmable
// divider model that can be told to hang on a chosen request.
module tb_centroid_div_scheduler;
  import centroid_div_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] sum_x, sum_y, num;
  logic         div_start;
  logic [31:0]  div_dividend, div_divisor;
  logic         div_ready = 1'b1;
  logic [31:0]  div_quotient = '0;
  logic [39:0]  avg_x;
  logic [35:0]  avg_y;
  logic [3:0]   valid_mask;
  logic         busy, done, timeout_err;
  state_e       state_dbg;

  always #5 clk = ~clk;

  centroid_div_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sum_x        (sum_x),
    .sum_y        (sum_y),
    .num          (num),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ready    (div_ready),
    .div_quotient (div_quotient),
    .avg_x        (avg_x),
    .avg_y        (avg_y),
    .valid_mask   (valid_mask),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- divider model ----------------
  int          lat = 1;
  int          hang_issue = -1;
  int          issue_cnt = 0;
  int          done_cnt = 0;
  int          div_cnt = 0;
  bit          hanging = 1'b0;
  logic [31:0] m_a, m_b;

  always @(negedge clk) begin
    if (reset) begin
      div_ready = 1'b1;
      div_cnt   = 0;
      hanging   = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (div_start) begin
        m_a       = div_dividend;
        m_b       = div_divisor;
        hanging   = (issue_cnt == hang_issue);
        issue_cnt++;
        div_ready = 1'b0;
        div_cnt   = lat;
      end else if (!hanging && div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          div_quotient = (m_b != 0) ? m_a / m_b : 32'hffff_ffff;
          div_ready    = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] t_sx[4], t_sy[4], t_n[4];
  int          r_ax[4], r_ay[4];
  logic [3:0]  r_mask;
  bit          r_err;
  int          r_issues;

  task automatic ref_pass(input int hang);
    int q, lim, v;
    r_err    = 1'b0;
    r_issues = 0;
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 2; a++) begin
        if (t_n[c] == 0) begin
          r_mask[c] = 1'b0;
        end else begin
          bit to;
          to = (r_issues == hang);
          r_issues++;
          if (to) begin
            r_err     = 1'b1;
            r_mask[c] = 1'b0;
          end else begin
            q   = int'((a == 1 ? t_sy[c] : t_sx[c]) / t_n[c]);
            lim = (a == 1) ? 479 : 639;
            v   = (q > lim || q < 0) ? lim : q;
            if (a == 0) begin
              r_ax[c]   = v;
              r_mask[c] = 1'b1;
            end else begin
              r_ay[c] = v;
            end
          end
        end
      end
    end
  endtask

  task automatic ref_reset();
    for (int c = 0; c < 4; c++) begin
      r_ax[c] = 0;
      r_ay[c] = 0;
    end
    r_mask = '0;
    r_err  = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    sum_x = {t_sx[3], t_sx[2], t_sx[1], t_sx[0]};
    sum_y = {t_sy[3], t_sy[2], t_sy[1], t_sy[0]};
    num   = {t_n[3], t_n[2], t_n[1], t_n[0]};
  endtask

  task automatic run_pass(input int l, input int hang, input bit restart);
    int cyc;
    lat        = l;
    hang_issue = hang;
    issue_cnt  = 0;
    done_cnt   = 0;
    ref_pass(hang);
    for (int k = 0; k < 4; k++) exp_q.push_back(r_ax[k]);
    for (int k = 0; k < 4; k++) exp_q.push_back(r_ay[k]);

    @(posedge clk); #1;
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", timeout_err, 0);

    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (restart && cyc == 5) begin
        sum_x = {4{$urandom()}};
        sum_y = {4{$urandom()}};
        num   = {4{32'd3}};
        start = 1'b1;
      end
    end
    check("done_seen", done, 1);
    check("busy_low_at_done", busy, 0);
    if (hang < 0) check("latency_bound", (cyc <= 8 * (l + 4) + 2), 1);

    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("div_start_pulses", issue_cnt, r_issues);
    check("busy_idle", busy, 0);
    check("valid_mask", valid_mask, r_mask);
    check("timeout_err", timeout_err, r_err);
    for (int k = 0; k < 4; k++)
      check($sformatf("avg_x%0d", k), avg_x[k*10 +: 10], exp_q.pop_front());
    for (int k = 0; k < 4; k++)
      check($sformatf("avg_y%0d", k), avg_y[k*9 +: 9], exp_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_div_start"}, div_start, 0);
    check({tag, "_avg_x"}, avg_x, 0);
    check({tag, "_avg_y"}, avg_y, 0);
    check({tag, "_mask"}, valid_mask, 0);
    check({tag, "_err"}, timeout_err, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    reset = 1'b1;
    start = 1'b0;
    sum_x = '0;
    sum_y = '0;
    num   = '0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // four full colors
    for (int k = 0; k < 4; k++) begin
      t_n[k]  = 10;
      t_sx[k] = 1000 * (k + 1);
      t_sy[k] = 500 + 100 * k;
    end
    run_pass(3, -1, 1'b0);

    // color 1 empty: its averages hold the previous pass values
    for (int k = 0; k < 4; k++) begin
      t_n[k]  = (k == 1) ? 0 : 4;
      t_sx[k] = 400 + 37 * k;
      t_sy[k] = 100 + 11 * k;
    end
    t_sx[1] = 9999;
    run_pass(2, -1, 1'b0);

    // clamping on color 0
    t_n[0] = 1; t_sx[0] = 7000; t_sy[0] = 9000;
    t_n[1] = 5; t_sx[1] = 50;   t_sy[1] = 45;
    run_pass(1, -1, 1'b0);

    // second start while busy is ignored
    for (int k = 0; k < 4; k++) begin
      t_n[k]  = 7 + k;
      t_sx[k] = 2100 + 300 * k;
      t_sy[k] = 1400 + 50 * k;
    end
    run_pass(4, -1, 1'b1);

    // divider hangs on request 2 (color 1, x)
    run_pass(2, 2, 1'b0);

    // reset in the WAIT state of job 4
    lat        = 6;
    hang_issue = -1;
    issue_cnt  = 0;
    @(posedge clk); #1;
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (issue_cnt < 5 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    while (state_dbg != ST_WAIT && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("reach_wait_job4", (g < 500), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midpass_reset");
    reset = 1'b0;
    ref_reset();
    run_pass(3, -1, 1'b0);

    // randomized passes
    for (int p = 0; p < 12; p++) begin
      int l, h;
      for (int k = 0; k < 4; k++) begin
        t_n[k]  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2000);
        t_sx[k] = $urandom_range(0, t_n[k] * 700 + 5);
        t_sy[k] = $urandom_range(0, t_n[k] * 560 + 5);
      end
      l = $urandom_range(1, 6);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      run_pass(l, h, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
